pla_sop_eval_pipe: RTL and testbench

- Runtime-programmable sum-of-products evaluator. It generalises the team's fixed, single-output optimised benchmark netlists (21 inputs, 1 output) to parameterised inputs, cubes and outputs.
- The cube table is loaded through a config port. Input vectors stream through a 2-stage valid/ready pipeline: AND-plane register, then OR-plane register.
- Used as the golden/emulation engine beside the synthesised benchmark netlists, so equivalence can be checked on the same stream.

---
 rtl/pla_pkg.sv | 28 ++
 rtl/pla_and_plane.sv | 33 +++
 rtl/pla_sop_eval_pipe.sv | 142 ++++++++++++++
 tb/tb_pla_sop_eval_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pla_pkg.sv
// rtl/pla_pkg.sv - shared types and helpers for the PLA sum-of-products evaluator
//
// Purpose: default geometry of the evaluator, the cube record layout and the
// cube-address-width helper used by the top level.
// Ports: none (package).

package pla_pkg;

  localparam int PLA_N_IN   = 21;
  localparam int PLA_N_CUBE = 16;
  localparam int PLA_N_OUT  = 1;

  // One product-term slot: care mask, literal values, output mask, valid bit.
  typedef struct packed {
    logic                 valid;
    logic [PLA_N_OUT-1:0] omask;
    logic [PLA_N_IN-1:0]  val;
    logic [PLA_N_IN-1:0]  care;
  } cube_t;

  localparam int CUBE_W = $bits(cube_t);

  // Cube address width; a single-slot table still gets a 1-bit address.
  function automatic int pla_aw(input int n_cube);
    return (n_cube <= 2) ? 1 : $clog2(n_cube);
  endfunction

endpackage

// File: rtl/pla_and_plane.sv
// rtl/pla_and_plane.sv - combinational N_CUBE-way cube match of one input vector
//
// Purpose: AND-plane of the evaluator; flags every valid slot whose cared-for
// literals all agree with the vector.
// Ports:
//   vec     in  N_IN             input vector
//   care    in  N_CUBE x N_IN    per-slot care masks
//   val     in  N_CUBE x N_IN    per-slot literal values
//   slot_v  in  N_CUBE           per-slot valid bits
//   hit     out N_CUBE           per-slot match

module pla_and_plane
  import pla_pkg::*;
#(
  parameter int N_IN   = PLA_N_IN,
  parameter int N_CUBE = PLA_N_CUBE
) (
  input  logic [N_IN-1:0]              vec,
  input  logic [N_CUBE-1:0][N_IN-1:0]  care,
  input  logic [N_CUBE-1:0][N_IN-1:0]  val,
  input  logic [N_CUBE-1:0]            slot_v,
  output logic [N_CUBE-1:0]            hit
);

  // A valid slot with an all-zero care mask matches everything.
  always_comb begin
    hit = '0;
    for (int k = 0; k < N_CUBE; k++) begin
      hit[k] = slot_v[k] & ~(|((vec ^ val[k]) & care[k]));
    end
  end

endmodule

// File: rtl/pla_sop_eval_pipe.sv
// rtl/pla_sop_eval_pipe.sv - runtime-programmable sum-of-products evaluator, 2-stage pipe
//
// Purpose: holds a programmable cube table and streams input vectors through an
// AND-plane register and an OR-plane register with valid/ready flow control.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   cfg_we/cfg_addr/cfg_care/cfg_val/cfg_omask   write one cube slot
//   cfg_clr                           invalidate all slots (wins over cfg_we)
//   out_pol                           per-output inversion, sampled at stage-2 load
//   in_valid/in_ready/in_data         input vector stream
//   out_valid/out_ready/out_data      result stream

module pla_sop_eval_pipe
  import pla_pkg::*;
#(
  parameter  int N_IN   = PLA_N_IN,
  parameter  int N_CUBE = PLA_N_CUBE,
  parameter  int N_OUT  = PLA_N_OUT,
  localparam int AW     = pla_aw(N_CUBE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [N_IN-1:0]   cfg_care,
  input  logic [N_IN-1:0]   cfg_val,
  input  logic [N_OUT-1:0]  cfg_omask,
  input  logic              cfg_clr,
  input  logic [N_OUT-1:0]  out_pol,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_data
);

  // Cube table; only the valid bits are reset.
  logic [N_CUBE-1:0][N_IN-1:0]  care_q, care_d;
  logic [N_CUBE-1:0][N_IN-1:0]  val_q, val_d;
  logic [N_CUBE-1:0][N_OUT-1:0] omask_q, omask_d;
  logic [N_CUBE-1:0]            slot_v_q, slot_v_d;

  // Pipeline state.
  logic                         s1_v_q, s1_v_d;
  logic                         s2_v_q, s2_v_d;
  logic [N_CUBE-1:0][N_OUT-1:0] term1_q, term1_d;
  logic [N_OUT-1:0]             out_data_q, out_data_d;

  logic                         cfg_hit;
  logic [N_CUBE-1:0]            hit;
  logic                         s1_load;
  logic                         s2_load;
  logic [N_OUT-1:0]             y;

  assign cfg_hit = cfg_we & (32'(cfg_addr) < N_CUBE);

  pla_and_plane #(
    .N_IN   (N_IN),
    .N_CUBE (N_CUBE)
  ) u_and_plane (
    .vec    (in_data),
    .care   (care_q),
    .val    (val_q),
    .slot_v (slot_v_q),
    .hit    (hit)
  );

  assign in_ready  = ~s1_v_q | ~s2_v_q | out_ready;
  assign s1_load   = in_valid & in_ready;
  assign s2_load   = s1_v_q & (~s2_v_q | out_ready);
  assign out_valid = s2_v_q;
  assign out_data  = out_data_q;

  // Table update: the match above reads the pre-write table, so a vector
  // accepted in the same cycle as a write sees the old contents.
  always_comb begin
    care_d   = care_q;
    val_d    = val_q;
    omask_d  = omask_q;
    slot_v_d = slot_v_q;
    if (cfg_hit) begin
      care_d[cfg_addr]  = cfg_care;
      val_d[cfg_addr]   = cfg_val;
      omask_d[cfg_addr] = cfg_omask;
    end
    if (cfg_clr) begin
      slot_v_d = '0;
    end else if (cfg_hit) begin
      slot_v_d[cfg_addr] = 1'b1;
    end
  end

  // Stage 1 captures each hit already gated by its slot's output mask, so a
  // rewrite of that slot while the vector is in flight cannot change its result.
  always_comb begin
    s1_v_d  = s1_load | (s1_v_q & ~s2_load);
    term1_d = term1_q;
    if (s1_load) begin
      for (int k = 0; k < N_CUBE; k++) begin
        term1_d[k] = {N_OUT{hit[k]}} & omask_q[k];
      end
    end
  end

  // OR-plane with per-output polarity.
  always_comb begin
    y = '0;
    for (int k = 0; k < N_CUBE; k++) begin
      y = y | term1_q[k];
    end
    y = y ^ out_pol;
  end

  always_comb begin
    s2_v_d     = s2_load | (s2_v_q & ~out_ready);
    out_data_d = s2_load ? y : out_data_q;
  end

  always_ff @(posedge clk) begin
    care_q  <= care_d;
    val_q   <= val_d;
    omask_q <= omask_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v_q   <= '0;
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      term1_q    <= '0;
      out_data_q <= '0;
    end else begin
      slot_v_q   <= slot_v_d;
      s1_v_q     <= s1_v_d;
      s2_v_q     <= s2_v_d;
      term1_q    <= term1_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_pla_sop_eval_pipe.sv
// tb/tb_pla_sop_eval_pipe.sv - self-checking bench for pla_sop_eval_pipe

module tb_pla_sop_eval_pipe;

  localparam int N_IN   = 21;
  localparam int N_CUBE = 16;
  localparam int N_OUT  = 2;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [N_IN-1:0]   cfg_care = '0;
  logic [N_IN-1:0]   cfg_val = '0;
  logic [N_OUT-1:0]  cfg_omask = '0;
  logic              cfg_clr = 1'b0;
  logic [N_OUT-1:0]  out_pol = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N_IN-1:0]   in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [N_OUT-1:0]  out_data;

  pla_sop_eval_pipe #(.N_IN(N_IN), .N_CUBE(N_CUBE), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care), .cfg_val(cfg_val),
    .cfg_omask(cfg_omask), .cfg_clr(cfg_clr), .out_pol(out_pol),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference table and in-flight results.
  logic [N_IN-1:0]  m_care  [N_CUBE];
  logic [N_IN-1:0]  m_val   [N_CUBE];
  logic [N_OUT-1:0] m_omask [N_CUBE];
  bit               m_valid [N_CUBE];

  typedef struct {
    logic [N_OUT-1:0] y;
    int               acc;
  } item_t;
  item_t q[$];

  int E = 0;            // rising edges seen
  int head_ready = 0;   // edge after which the oldest result is presentable
  int last_pop = 0;
  int n_out_seen = 0;
  logic [N_OUT-1:0] last_out = '0;

  function automatic logic [N_OUT-1:0] model_eval(input logic [N_IN-1:0] d);
    logic [N_OUT-1:0] r = '0;
    for (int k = 0; k < N_CUBE; k++)
      if (m_valid[k] && (((d ^ m_val[k]) & m_care[k]) == '0)) r = r | m_omask[k];
    return r ^ out_pol;
  endfunction

  bit    exp_ov, exp_ir;
  item_t it;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      for (int k = 0; k < N_CUBE; k++) m_valid[k] = 0;
    end else begin
      exp_ov = (q.size() > 0) && (E >= head_ready);
      exp_ir = (q.size() < 2) || out_ready;
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) chk("out_data", 32'(out_data), 32'(q[0].y));
      if (exp_ov && out_ready) begin
        last_out = out_data;
        n_out_seen++;
        void'(q.pop_front());
        last_pop = E + 1;
        if (q.size() > 0) head_ready = (q[0].acc + 1 > E + 1) ? q[0].acc + 1 : E + 1;
      end
      if (in_valid && exp_ir) begin
        it.y = model_eval(in_data);
        it.acc = E + 1;
        if (q.size() == 0) head_ready = (E + 2 > last_pop) ? E + 2 : last_pop;
        q.push_back(it);
      end
      if (cfg_clr) begin
        for (int k = 0; k < N_CUBE; k++) m_valid[k] = 0;
      end else if (cfg_we) begin
        m_care[cfg_addr] = cfg_care;
        m_val[cfg_addr] = cfg_val;
        m_omask[cfg_addr] = cfg_omask;
        m_valid[cfg_addr] = 1;
      end
    end
    E++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N_IN-1:0] d);
    bit ok = 0;
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      cyc();
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) cyc();
    cyc();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic cfg_write(input int a, input logic [N_IN-1:0] c, input logic [N_IN-1:0] v,
                           input logic [N_OUT-1:0] om);
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_care = c;
    cfg_val = v;
    cfg_omask = om;
    cyc();
    cfg_we = 1'b0;
  endtask

  localparam logic [N_IN-1:0] T1_CARE = 21'h1D0011;
  localparam logic [N_IN-1:0] T1_VAL  = 21'h1D0000;

  logic [N_IN-1:0] vecs [4];
  int idx;
  int seen0;
  bit ok;

  initial begin
    // Reset / empty table.
    repeat (3) cyc();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    cyc();
    send('0);
    drain();
    chk("empty_pol0", 32'(last_out), 32'd0);
    out_pol = 2'b11;
    send('0);
    drain();
    chk("empty_pol1", 32'(last_out), 32'd3);
    out_pol = 2'b00;

    // t1 benchmark term.
    cfg_write(0, T1_CARE, T1_VAL, 2'b01);
    cyc();
    chk("model_t1_hit", 32'(model_eval(T1_VAL)), 32'd1);
    send(T1_VAL);
    drain();
    chk("t1_hit", 32'(last_out), 32'd1);
    send(T1_VAL | 21'h1);
    drain();
    chk("t1_miss", 32'(last_out), 32'd0);

    // Two-output OR plane.
    cfg_write(1, 21'h2, 21'h2, 2'b01);
    cfg_write(2, 21'h4, 21'h0, 2'b10);
    send(21'h2);
    drain();
    chk("or_plane_11", 32'(last_out), 32'd3);
    send(21'h4);
    drain();
    chk("or_plane_00", 32'(last_out), 32'd0);

    // Backpressure: 4 vectors, consumer stalled for 5 cycles.
    vecs[0] = 21'h2; vecs[1] = 21'h4; vecs[2] = 21'h0; vecs[3] = 21'h6;
    seen0 = n_out_seen;
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    in_data = vecs[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ok = in_ready;
      cyc();
      if (ok) begin
        idx++;
        if (idx < 4) in_data = vecs[idx]; else in_valid = 1'b0;
      end
    end
    chk("bp_accepts", 32'(idx), 32'd2);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      @(negedge clk);
      ok = in_ready;
      cyc();
      if (ok) begin
        idx++;
        if (idx < 4) in_data = vecs[idx]; else in_valid = 1'b0;
      end
    end
    drain();
    chk("bp_results", 32'(n_out_seen - seen0), 32'd4);

    // Config race.
    cfg_clr = 1'b1;
    cyc();
    cfg_clr = 1'b0;
    cfg_we = 1'b1; cfg_addr = 0; cfg_care = '0; cfg_val = '0; cfg_omask = 2'b01;
    in_valid = 1'b1; in_data = '0;
    cyc();
    cfg_we = 1'b0;
    in_valid = 1'b0;
    drain();
    chk("race_old_table", 32'(last_out), 32'd0);
    send('0);
    drain();
    chk("race_new_table", 32'(last_out), 32'd1);
    cfg_clr = 1'b1;
    cfg_write(3, '0, '0, 2'b10);
    cfg_clr = 1'b0;
    send('0);
    drain();
    chk("clr_beats_we", 32'(last_out), 32'd0);

    // Mid-stream reset with both stages full.
    cfg_write(0, '0, '0, 2'b11);
    out_pol = 2'b01;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 21'h5;
    cyc();
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("pre_reset_full", 32'({out_valid, in_ready}), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_data", 32'(out_data), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    send(21'h5);
    drain();
    chk("post_reset_pol", 32'(last_out), 32'd1);

    // Randomised traffic with concurrent reprogramming.
    out_pol = 2'($urandom);
    seen0 = n_out_seen;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = N_IN'($urandom);
      out_ready = ($urandom_range(9) < 7);
      cfg_we    = ($urandom_range(7) == 0);
      cfg_addr  = AW'($urandom);
      cfg_care  = N_IN'($urandom & $urandom & $urandom);
      cfg_val   = N_IN'($urandom);
      cfg_omask = 2'($urandom);
      cfg_clr   = ($urandom_range(199) == 0);
      cyc();
    end
    cfg_we = 1'b0;
    cfg_clr = 1'b0;
    drain();
    checks++;
    if (n_out_seen - seen0 < 1000) begin
      failures++;
      $display("FAIL random_throughput actual=%0d required=>=1000", n_out_seen - seen0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
